// File: rtl/eq_gain_loader_if.sv
// Gain RAM CPU write port as seen by the equalizer coefficient loader.
// The loader is the master; the gain RAM side is the slave.
interface eq_gain_loader_if;
  logic       eq_wr;
  logic       eq_wr_rst;
  logic [7:0] eq_gain_lsb;
  logic [7:0] eq_gain_msb;
  logic       wr_addr_zero;

  modport master (
    output eq_wr,
    output eq_wr_rst,
    output eq_gain_lsb,
    output eq_gain_msb,
    input  wr_addr_zero
  );

  modport slave (
    input  eq_wr,
    input  eq_wr_rst,
    input  eq_gain_lsb,
    input  eq_gain_msb,
    output wr_addr_zero
  );
endinterface

// File: rtl/eq_gain_loader.sv
// Shadow-bank equalizer gain loader: commits a snapshot into the gain RAM in one burst between frames.
// Optional macro EQ_GAIN_RAMP_EN: slew each gain by RAMP_STEP per frame until converged.
module eq_gain_loader #(
  parameter int          NUM_BANDS = 4,
  parameter logic [15:0] RAMP_STEP = 16'h0040
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_gain_wr,
  input  logic [3:0]                cpu_gain_sel,
  input  logic [15:0]               cpu_gain,
  input  logic                      commit,
  input  logic                      err_clr,
  input  logic                      eq_run_en,
  input  logic                      frame_start,
  input  logic                      frame_done,
  eq_gain_loader_if.master          ram,
  output logic                      busy,
  output logic                      done,
  output logic                      addr_err,
  output logic                      overrun_err
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RST,
    CHECK,
    WRITE,
    GAP,
    DONE
  } state_t;

  localparam logic [4:0] NB   = 5'(NUM_BANDS);
  localparam logic [3:0] LAST = 4'(NUM_BANDS - 1);

  state_t      state_q, state_d;
  logic [15:0] shadow_q [16];
  logic [15:0] shadow_d [16];
  logic [15:0] snap_q   [16];
  logic [15:0] snap_d   [16];
  logic [3:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic        rearm_q, rearm_d;
  logic        wr_q, wr_d;
  logic        wr_rst_q, wr_rst_d;
  logic [15:0] gain_q, gain_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic        ovr_q, ovr_d;
  logic        conv;
  logic [15:0] wval;

`ifdef EQ_GAIN_RAMP_EN
  localparam logic signed [16:0] STEP_P = {1'b0, RAMP_STEP};
  localparam logic signed [16:0] STEP_N = -STEP_P;

  logic [15:0]        cur_q [16];
  logic [15:0]        cur_d [16];
  logic signed [16:0] diff;
`endif

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    rearm_d    = rearm_q;
    addr_err_d = addr_err_q;
    ovr_d      = ovr_q;
    conv       = 1'b1;
    wval       = 16'h0000;
`ifdef EQ_GAIN_RAMP_EN
    cur_d      = cur_q;
    diff       = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (cur_q[i[3:0]] != snap_q[i[3:0]]) conv = 1'b0;
    end
`endif

    if (cpu_gain_wr && ({1'b0, cpu_gain_sel} < NB))
      shadow_d[cpu_gain_sel] = cpu_gain;

    if (commit && state_q != IDLE) pending_d = 1'b1;

    // a fresh error event in the same cycle overrides the clear
    if (err_clr) begin
      addr_err_d = 1'b0;
      ovr_d      = 1'b0;
    end
    if (state_q == CHECK && !ram.wr_addr_zero) addr_err_d = 1'b1;
    if (frame_start && (state_q == RST || state_q == CHECK ||
                        state_q == WRITE || state_q == GAP))
      ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (commit || pending_q) begin
          snap_d    = shadow_d;
          pending_d = 1'b0;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (!eq_run_en || (frame_done && !frame_start))
          state_d = RST;
      end
      RST:   state_d = CHECK;
      CHECK: begin
        idx_d   = 4'd0;
        state_d = WRITE;
      end
      WRITE: begin
`ifdef EQ_GAIN_RAMP_EN
        cur_d[idx_q] = gain_q;
`endif
        state_d = GAP;
      end
      GAP: begin
        if (idx_q == LAST) begin
          rearm_d = pending_q || commit || !conv;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = WRITE;
        end
      end
      DONE: begin
        if (rearm_q) begin
          snap_d    = shadow_d;
          pending_d = 1'b0;
          state_d   = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef EQ_GAIN_RAMP_EN
    // move toward the target without overshoot
    diff = $signed({snap_q[idx_d][15], snap_q[idx_d]}) -
           $signed({cur_q[idx_d][15], cur_q[idx_d]});
    if (diff > STEP_P)      wval = cur_q[idx_d] + RAMP_STEP;
    else if (diff < STEP_N) wval = cur_q[idx_d] - RAMP_STEP;
    else                    wval = snap_q[idx_d];
`else
    wval = snap_q[idx_d];
`endif

    wr_rst_d = (state_d == RST);
    wr_d     = (state_d == WRITE);
    if (state_d == WRITE)    gain_d = wval;
    else if (state_d == GAP) gain_d = gain_q;
    else                     gain_d = 16'h0000;
    done_d = (state_d == DONE) && conv;
    busy_d = (state_d != IDLE) && !(state_d == DONE && !rearm_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '{default: '0};
      snap_q     <= '{default: '0};
      idx_q      <= 4'd0;
      pending_q  <= 1'b0;
      rearm_q    <= 1'b0;
      wr_q       <= 1'b0;
      wr_rst_q   <= 1'b0;
      gain_q     <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef EQ_GAIN_RAMP_EN
      cur_q      <= '{default: '0};
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      rearm_q    <= rearm_d;
      wr_q       <= wr_d;
      wr_rst_q   <= wr_rst_d;
      gain_q     <= gain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      ovr_q      <= ovr_d;
`ifdef EQ_GAIN_RAMP_EN
      cur_q      <= cur_d;
`endif
    end
  end

  assign ram.eq_wr       = wr_q;
  assign ram.eq_wr_rst   = wr_rst_q;
  assign ram.eq_gain_lsb = gain_q[7:0];
  assign ram.eq_gain_msb = gain_q[15:8];
  assign busy            = busy_q;
  assign done            = done_q;
  assign addr_err        = addr_err_q;
  assign overrun_err     = ovr_q;

endmodule
